// File: rtl/feature_row_fetch_if.sv
// Bundle for feature_row_fetch: the feature-memory read port and the
// downstream row stream (valid/ready with row index and last flag).
// master = the fetch sequencer, slave = memory + downstream consumer.
interface feature_row_fetch_if #(
    parameter int ROW_BITS = 480,
    parameter int AW       = 3
);
    logic                read_feature_en;
    logic [AW-1:0]       read_address;
    logic [ROW_BITS-1:0] read_data;
    logic                out_valid;
    logic                out_ready;
    logic [ROW_BITS-1:0] out_row;
    logic [AW-1:0]       out_row_index;
    logic                out_last;

    modport master (
        output read_feature_en, read_address, out_valid, out_row, out_row_index, out_last,
        input  read_data, out_ready
    );

    modport slave (
        input  read_feature_en, read_address, out_valid, out_row, out_row_index, out_last,
        output read_data, out_ready
    );
endinterface

// File: rtl/feature_row_fetch.sv
// feature_row_fetch: walks the GCN feature matrix one row at a time.
// Each row is read from feature memory, captured once the read latency has
// elapsed, and held on a valid/ready stream until accepted. A done pulse
// follows acceptance of the last row.
// Optional macro FEATURE_FETCH_STALL_CNT_EN adds a saturating 16-bit
// stall_count output (cycles with out_valid=1 and out_ready=0).
module feature_row_fetch #(
    parameter int FEATURE_ROWS          = 6,
    parameter int FEATURE_COLS          = 96,
    parameter int FEATURE_WIDTH         = 5,
    parameter int READ_LATENCY          = 1,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       flush,
    feature_row_fetch_if.master        bus,
    output logic                       done,
    output logic                       busy
`ifdef FEATURE_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    localparam int ROW_BITS = FEATURE_COLS * FEATURE_WIDTH;
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [COUNTER_FEATURE_WIDTH-1:0] row;
    logic [COUNTER_FEATURE_WIDTH-1:0] row_next;
    logic [2:0]                       lat;
    logic [2:0]                       lat_next;
    logic                             capture;
    logic [ROW_BITS-1:0]              out_row_q;
    logic [COUNTER_FEATURE_WIDTH-1:0] out_index_q;

    // State register; reset aborts any pass immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, row stepping, latency countdown and capture strobe.
    always_comb begin
        state_next = state;
        row_next   = row;
        lat_next   = lat;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    row_next   = '0;
                end
            end
            READ: begin
                lat_next   = LAT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                // Data is on read_data in the cycle the countdown shows 1.
                if (lat <= 3'd1) begin
                    capture    = 1'b1;
                    lat_next   = '0;
                    state_next = HOLD;
                end else begin
                    lat_next = lat - 3'd1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Row count is not a power of two, so wrap explicitly.
                    if (row == LAST_ROW) begin
                        row_next   = '0;
                        state_next = DONE;
                    end else begin
                        row_next   = row + 1'b1;
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Abort wins over start, handshake and any pending capture.
        if (flush) begin
            state_next = IDLE;
            row_next   = '0;
            lat_next   = '0;
            capture    = 1'b0;
        end
    end

    // Row counter, latency counter and the captured output row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row         <= '0;
            lat         <= '0;
            out_row_q   <= '0;
            out_index_q <= '0;
        end else begin
            row <= row_next;
            lat <= lat_next;
            if (capture) begin
                out_row_q   <= bus.read_data;
                out_index_q <= row;
            end
        end
    end

    // Outputs are pure decodes of registered state, so no input reaches them.
    always_comb begin
        bus.read_feature_en = (state == READ);
        bus.read_address    = row;
        bus.out_valid       = (state == HOLD);
        bus.out_row         = out_row_q;
        bus.out_row_index   = out_index_q;
        bus.out_last        = (state == HOLD) && (out_index_q == LAST_ROW);
        done                = (state == DONE);
        busy                = (state != IDLE);
    end

`ifdef FEATURE_FETCH_STALL_CNT_EN
    // Backpressure counter: restarts with each accepted pass, survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (state == IDLE && start && !flush) begin
            stall_count <= '0;
        end else if ((state == HOLD) && !bus.out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/feature_row_fetch.md
Name: feature_row_fetch

Overview:
- Sequencer that walks the feature matrix row by row for the GCN transformation stage.
- Issues a read to the feature memory for each row and captures the returned row.
- Presents the row downstream on a valid/ready handshake with its row index.
- Steps the row index 0..FEATURE_ROWS-1 with wrap to 0, and emits a done pulse after the last row is accepted.

Parameters:
- FEATURE_ROWS, 6, number of feature rows per pass.
- FEATURE_COLS, 96, elements per feature row.
- FEATURE_WIDTH, 5, bits per element.
- READ_LATENCY, 1, cycles from read_en to valid read_data; legal range 1..7.
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index/address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately.
- start  input  1  begin a pass; sampled only in IDLE.
- flush  input  1  synchronous abort to IDLE, no done.
- read_feature_en  output  1  one-cycle feature memory read strobe.
- read_address  output  COUNTER_FEATURE_WIDTH  row being read.
- read_data  input  FEATURE_COLS*FEATURE_WIDTH  memory row data, valid READ_LATENCY cycles after read_feature_en.
- out_valid  output  1  row data valid.
- out_ready  input  1  downstream accepts.
- out_row  output  FEATURE_COLS*FEATURE_WIDTH  captured row.
- out_row_index  output  COUNTER_FEATURE_WIDTH  index of out_row.
- out_last  output  1  out_valid AND out_row_index==FEATURE_ROWS-1.
- done  output  1  one-cycle pulse after the last row is accepted.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0) gives:
  - state=IDLE, row counter=0, latency counter=0.
  - All outputs 0, including out_row and read_address.
- States are IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - start=1 moves to READ with row=0.
  - start is ignored in all other states.
- READ (one cycle):
  - read_feature_en=1, read_address=row.
  - Latency counter loads READ_LATENCY, then the FSM goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, read_data is registered into out_row and row is registered into out_row_index.
  - The FSM then goes to HOLD.
  - If a read strobe occurs in cycle c, out_valid first asserts in cycle c+READ_LATENCY+1.
- HOLD:
  - out_valid=1; out_row and out_row_index are held stable until out_valid&&out_ready.
  - On handshake with row==FEATURE_ROWS-1: row wraps to 0 and the FSM goes to DONE.
  - On handshake otherwise: row+1 and the FSM goes to READ.
  - With out_ready held high, the row period is READ_LATENCY+2 cycles.
- DONE: done=1 for one cycle, then IDLE.
- flush=1 in any state:
  - Next state IDLE, row=0, out_valid=0, no done pulse.
  - Any in-flight read_data is discarded.
  - flush has priority over start and over a handshake in the same cycle.
- Output registering:
  - read_feature_en, out_valid and done are registered state decodes with no combinational path from inputs.
  - out_last is the combinational AND of registered signals.
- Row counter never exceeds FEATURE_ROWS-1; the non-power-of-2 wrap is explicit.
- Reset asserted mid-pass aborts immediately. After reset releases, the block waits in IDLE for a new start.

Optional Feature:
- Macro FEATURE_FETCH_STALL_CNT_EN.
- When defined:
  - Adds output port stall_count (16 bits).
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on reset and when start is accepted in IDLE.
  - Not cleared by flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, out_ready=1, start pulsed in cycle 0:
  - read_feature_en in cycles 1,4,7,10,13,16 with read_address 0..5.
  - out_valid in cycles 3,6,...,18, with out_last only in cycle 18.
  - done in cycle 19; busy from cycle 1 to 19.
- Backpressure: out_ready=0 for 5 cycles while row 2 is presented:
  - out_row and out_row_index=2 held stable.
  - The next read_feature_en comes only after the handshake.
  - With the macro defined, stall_count=5.
- READ_LATENCY=3, memory returns read_data=row pattern (index replicated):
  - out_valid comes 4 cycles after each strobe.
  - out_row matches the pattern for its index.
- flush asserted while in WAIT for row 3:
  - IDLE next cycle, out_valid never asserts for row 3, no done pulse.
  - A following start re-reads from address 0.
- rst driven low mid-HOLD, asynchronous to clk:
  - All outputs go to 0 immediately.
  - After release, start is ignored until IDLE is sampled, then a full 6-row pass completes.
- start held high through DONE: exactly one pass per start acceptance in IDLE; the second pass begins with read_feature_en 2 cycles after done.
